// File: rtl/gate_arb_pkg.sv
// Shared types and constants for the gate_arbiter slice.
package gate_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 32;
  localparam int CNTW_DEF  = 16;

  // Width of a requester id; never narrower than one bit.
  function automatic int id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/gate_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last'.
module rr_pick
  import gate_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = id_width(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  winner,
  output logic            valid
);

  logic [2*NREQ-1:0] dbl_s;
  logic [2*NREQ-1:0] mask_s;
  logic              found_s;

  // Doubled request vector masked to the window last+1 .. last+NREQ, then lowest set bit wins.
  always_comb begin
    dbl_s   = {req, req};
    mask_s  = '0;
    winner  = '0;
    found_s = 1'b0;
    for (int j = 0; j < 2 * NREQ; j++) begin
      if ((j > int'(last)) && (j <= int'(last) + NREQ)) begin
        mask_s[j] = dbl_s[j];
      end else begin
        mask_s[j] = 1'b0;
      end
    end
    for (int j = 0; j < 2 * NREQ; j++) begin
      if (!found_s && mask_s[j]) begin
        found_s = 1'b1;
        winner  = IDW'(j % NREQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin sequencer sharing one external AND unit among NREQ requesters.
module gate_arbiter
  import gate_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     opa,
  input  logic [NREQ*WIDTH-1:0]     opb,
  output logic [NREQ-1:0]           gnt,
  output logic [WIDTH-1:0]          gate_a,
  output logic [WIDTH-1:0]          gate_b,
  input  logic [WIDTH-1:0]          gate_q,
  output logic                      resp_valid,
  output logic [id_width(NREQ)-1:0] resp_id,
  output logic [WIDTH-1:0]          resp_data,
  output logic                      busy,
  output logic [CNTW-1:0]           op_cnt
);

  localparam int IDW = id_width(NREQ);
  localparam logic [NREQ-1:0] ONEHOT0   = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0]  LAST_INIT = IDW'(NREQ - 1);
  localparam logic [CNTW-1:0] CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [IDW-1:0]    last_r;
  logic [NREQ-1:0]   gnt_r;
  logic [WIDTH-1:0]  gate_a_r;
  logic [WIDTH-1:0]  gate_b_r;
  logic              resp_valid_r;
  logic [IDW-1:0]    resp_id_r;
  logic [WIDTH-1:0]  resp_data_r;
  logic [CNTW-1:0]   op_cnt_r;

  logic [IDW-1:0]    win_s;
  logic              any_s;
  logic [WIDTH-1:0]  sel_a_s;
  logic [WIDTH-1:0]  sel_b_s;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req),
    .last   (last_r),
    .winner (win_s),
    .valid  (any_s)
  );

  // Route the winning requester's operand slices toward the shared unit.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_s == IDW'(i)) begin
        sel_a_s = opa[i*WIDTH +: WIDTH];
        sel_b_s = opb[i*WIDTH +: WIDTH];
      end else begin
        sel_a_s = sel_a_s;
        sel_b_s = sel_b_s;
      end
    end
  end

  // Two-state sequencer: grant and launch in IDLE, capture result in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_r       <= LAST_INIT;
      gnt_r        <= '0;
      gate_a_r     <= '0;
      gate_b_r     <= '0;
      resp_valid_r <= 1'b0;
      resp_id_r    <= '0;
      resp_data_r  <= '0;
      op_cnt_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          resp_valid_r <= 1'b0;
          if (any_s) begin
            gnt_r    <= ONEHOT0 << win_s;
            gate_a_r <= sel_a_s;
            gate_b_r <= sel_b_s;
            last_r   <= win_s;
            state_r  <= EXEC;
          end else begin
            gnt_r    <= '0;
          end
        end
        EXEC: begin
          resp_data_r  <= gate_q;
          resp_id_r    <= last_r;
          resp_valid_r <= 1'b1;
          op_cnt_r     <= op_cnt_r + CNT_ONE;
          gnt_r        <= '0;
          state_r      <= IDLE;
        end
        default: begin
          gnt_r        <= '0;
          resp_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign gnt        = gnt_r;
  assign gate_a     = gate_a_r;
  assign gate_b     = gate_b_r;
  assign resp_valid = resp_valid_r;
  assign resp_id    = resp_id_r;
  assign resp_data  = resp_data_r;
  assign busy       = (state_r == EXEC);
  assign op_cnt     = op_cnt_r;

endmodule

// File: tb/tb_gate_arbiter.sv
// Scoreboard bench for gate_arbiter: random and directed requests vs. a round-robin model.
module tb_gate_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] opa;
  logic [NREQ*WIDTH-1:0] opb;

  logic [NREQ-1:0]  gnt, gnt4;
  logic [WIDTH-1:0] gate_a, gate_b, gate_q, gate_a4, gate_b4, gate_q4;
  logic             resp_valid, resp_valid4, busy, busy4;
  logic [1:0]       resp_id, resp_id4;
  logic [WIDTH-1:0] resp_data, resp_data4;
  logic [15:0]      op_cnt;
  logic [3:0]       op_cnt4;

  // Shared AND unit with its spare inputs tied to all-ones.
  assign gate_q  = gate_a  & gate_b  & {WIDTH{1'b1}};
  assign gate_q4 = gate_a4 & gate_b4 & {WIDTH{1'b1}};

  gate_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb),
    .gnt(gnt), .gate_a(gate_a), .gate_b(gate_b), .gate_q(gate_q),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy), .op_cnt(op_cnt)
  );

  gate_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb),
    .gnt(gnt4), .gate_a(gate_a4), .gate_b(gate_b4), .gate_q(gate_q4),
    .resp_valid(resp_valid4), .resp_id(resp_id4), .resp_data(resp_data4),
    .busy(busy4), .op_cnt(op_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          id;
    logic [31:0] data;
    int          cnt;
  } exp_t;

  exp_t        resp_q[$];
  int          gseq[$];
  int          m_last;
  bit          m_exec, m_resp;
  logic [3:0]  m_gnt;
  logic [31:0] m_ga, m_gb;
  int          m_done;

  initial begin
    m_last = NREQ - 1; m_exec = 0; m_resp = 0; m_gnt = '0;
    m_ga = '0; m_gb = '0; m_done = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_last = NREQ - 1; m_exec = 0; m_resp = 0; m_gnt = '0;
        m_ga = '0; m_gb = '0; m_done = 0;
        resp_q.delete();
      end else if (m_exec) begin
        m_exec = 0; m_gnt = '0; m_resp = 1; m_done++;
      end else begin
        m_resp = 0;
        m_gnt  = '0;
        if (req != 4'b0000) begin
          int w;
          exp_t e;
          w = -1;
          for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last + k) % NREQ;
            if (w < 0 && req[c]) w = c;
          end
          m_gnt   = 4'(1 << w);
          m_ga    = opa[w*WIDTH +: WIDTH];
          m_gb    = opb[w*WIDTH +: WIDTH];
          m_last  = w;
          m_exec  = 1;
          e.id    = w;
          e.data  = m_ga & m_gb;
          e.cnt   = m_done + 1;
          resp_q.push_back(e);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("gnt", 64'(gnt), 64'(m_gnt));
      check("busy", 64'(busy), 64'(m_exec));
      check("resp_valid", 64'(resp_valid), 64'(m_resp));
      check("gate_a", 64'(gate_a), 64'(m_ga));
      check("gate_b", 64'(gate_b), 64'(m_gb));
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) gseq.push_back(i);
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = resp_q.pop_front();
          check("resp_id", 64'(resp_id), 64'(e.id));
          check("resp_data", 64'(resp_data), 64'(e.data));
          check("op_cnt", 64'(op_cnt), 64'(e.cnt % 65536));
          check("op_cnt4", 64'(op_cnt4), 64'(e.cnt % 16));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit drop_en;

  function automatic int gs(input int i);
    if (i < gseq.size()) return gseq[i];
    else return -1;
  endfunction

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (drop_en && gnt[i]) req[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    opa[i*WIDTH +: WIDTH] = a;
    opb[i*WIDTH +: WIDTH] = b;
  endtask

  initial begin
    rst = 1'b1; req = '0; opa = '0; opb = '0; drop_en = 1'b1;
    do_reset();

    // reset values
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_gate_a", 64'(gate_a), 64'(0));
    check("rst_gate_b", 64'(gate_b), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_id", 64'(resp_id), 64'(0));
    check("rst_resp_data", 64'(resp_data), 64'(0));
    check("rst_op_cnt", 64'(op_cnt), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // A: single request from requester 0
    set_ops(0, 32'hFFFF0000, 32'h0F0F0F0F);
    req = 4'b0001;
    repeat (4) step();
    check("A_data", 64'(resp_data), 64'(32'h0F0F0000));
    check("A_id", 64'(resp_id), 64'(0));
    check("A_cnt", 64'(op_cnt), 64'(1));

    // B: all four continuously requesting
    do_reset();
    gseq.delete();
    drop_en = 1'b0;
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'hFFFFFFFF, 32'(i));
    req = 4'b1111;
    repeat (10) step();
    req = 4'b0000;
    drop_en = 1'b1;
    repeat (2) step();
    check("B_len", 64'(gseq.size()), 64'(5));
    check("B_g0", 64'(gs(0)), 64'(0));
    check("B_g1", 64'(gs(1)), 64'(1));
    check("B_g2", 64'(gs(2)), 64'(2));
    check("B_g3", 64'(gs(3)), 64'(3));
    check("B_g4", 64'(gs(4)), 64'(0));

    // C: last pointer at 1, requests 0 and 3
    do_reset();
    req = 4'b0010;
    repeat (3) step();
    gseq.delete();
    req = 4'b1001;
    repeat (6) step();
    check("C_len", 64'(gseq.size()), 64'(2));
    check("C_g0", 64'(gs(0)), 64'(3));
    check("C_g1", 64'(gs(1)), 64'(0));

    // D: zero and all-ones operands
    set_ops(2, 32'h00000000, 32'hFFFFFFFF);
    req = 4'b0100;
    repeat (3) step();
    check("D_zero", 64'(resp_data), 64'(32'h00000000));
    set_ops(2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    req = 4'b0100;
    repeat (3) step();
    check("D_ones", 64'(resp_data), 64'(32'hFFFFFFFF));

    // E: reset while an operation is in flight
    drop_en = 1'b0;
    set_ops(0, 32'h12345678, 32'hFFFFFFFF);
    req = 4'b0001;
    step();
    rst = 1'b1;
    req = 4'b0000;
    step();
    check("E_gnt", 64'(gnt), 64'(0));
    check("E_valid", 64'(resp_valid), 64'(0));
    check("E_cnt", 64'(op_cnt), 64'(0));
    check("E_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    gseq.delete();
    drop_en = 1'b1;
    set_ops(3, 32'hA5A5A5A5, 32'h0000FFFF);
    req = 4'b1001;
    repeat (6) step();
    check("E_first", 64'(gs(0)), 64'(0));
    check("E_second", 64'(gs(1)), 64'(3));

    // F: seventeen operations on one requester, counter wrap on the narrow instance
    do_reset();
    drop_en = 1'b0;
    set_ops(1, $urandom, $urandom);
    req = 4'b0010;
    repeat (34) step();
    req = 4'b0000;
    drop_en = 1'b1;
    step();
    check("F_cnt16", 64'(op_cnt), 64'(17));
    check("F_cnt4", 64'(op_cnt4), 64'(1));

    // G: random traffic
    for (int n = 0; n < 400; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && !gnt[i] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0:       set_ops(i, 32'h00000000, $urandom);
            1:       set_ops(i, 32'hFFFFFFFF, 32'hFFFFFFFF);
            default: set_ops(i, $urandom, $urandom);
          endcase
          req[i] = 1'b1;
        end
      end
    end
    req = 4'b0000;
    repeat (4) step();
    check("drain", 64'(resp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_arbiter.md
Name: gate_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one parameterised bitwise AND unit (an instance of `andgate`) among NREQ requesters.
- Each granted requester supplies two WIDTH-bit operands. The block drives them onto the shared unit's first two inputs and registers the unit's result. It returns the result tagged with the requester id.
- The parent ties the AND unit's remaining inputs to all-ones.
- The block sits between requesting datapath stages and the shared logic unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width.
- CNTW, 16, width of completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; held high with operands stable until gnt seen.
- opa  input  NREQ*WIDTH  flattened operand A; slice i belongs to requester i.
- opb  input  NREQ*WIDTH  flattened operand B; slice i belongs to requester i.
- gnt  output  NREQ  registered one-hot grant, one-cycle pulse.
- gate_a  output  WIDTH  operand A to shared AND unit.
- gate_b  output  WIDTH  operand B to shared AND unit.
- gate_q  input  WIDTH  combinational result from shared AND unit.
- resp_valid  output  1  one-cycle pulse, result valid.
- resp_id  output  $clog2(NREQ)  requester the result belongs to.
- resp_data  output  WIDTH  registered result.
- busy  output  1  high while in EXEC.
- op_cnt  output  CNTW  completed operations, wraps modulo 2^CNTW.

Behaviour:
- Clock and reset are decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state=IDLE; gnt=0; gate_a=0; gate_b=0.
  - resp_valid=0; resp_id=0; resp_data=0; op_cnt=0.
  - last pointer = NREQ-1, so requester 0 has highest priority after reset.
- FSM has two states, IDLE and EXEC.
- IDLE:
  - If req==0, stay in IDLE, gnt=0.
  - Otherwise pick winner w = first asserted req scanning last+1, last+2, ... modulo NREQ.
  - At the next edge: gnt<=onehot(w); gate_a<=opa[w]; gate_b<=opb[w]; last<=w; state<=EXEC.
- EXEC:
  - gate_q is sampled.
  - At the next edge: resp_data<=gate_q; resp_id<=last; resp_valid<=1; op_cnt<=op_cnt+1; gnt<=0; state<=IDLE.
- Latency and throughput:
  - gnt rises 1 cycle after req is sampled in IDLE.
  - resp_valid rises 2 cycles after that sample.
  - Throughput is one operation per 2 cycles.
- Handshake rules:
  - A requester deasserts req on the edge after it sees gnt.
  - A req still high when IDLE resamples is treated as a new request.
  - req changes during EXEC are ignored.
- gate_a and gate_b hold their last values in IDLE; there is no zeroing between operations.
- resp_valid is high for exactly one cycle; resp_data and resp_id hold until the next response.
- gnt and resp_valid are never high in the same cycle.
- Simultaneous requests: exactly one grant, chosen by round-robin. A continuously requesting set is served in rotating order with no starvation. Worst-case wait is NREQ operations.
- Single requester repeatedly: it is granted every 2 cycles regardless of the last pointer.
- op_cnt wraps from 2^CNTW-1 to 0 without a flag.
- Reset during EXEC:
  - The in-flight operation is discarded; no resp_valid is produced.
  - All outputs return to reset values on that edge.
  - The last pointer returns to NREQ-1.

Decomposition:
- Shared package `gate_arb_pkg`:
  - state typedef {IDLE, EXEC};
  - default NREQ/WIDTH constants;
  - id-width helper.
- One natural sub-module, `rr_pick`: combinational round-robin picker.
  - Inputs: req, last.
  - Outputs: winner id, any-valid.
  - Implemented as a double-width masked priority scan.

Test Plan:
- Reset then single request: req=4'b0001, opa[0]=32'hFFFF0000, opb[0]=32'h0F0F0F0F → gnt=4'b0001 at cycle+1; resp_valid at cycle+2 with resp_id=0, resp_data=32'h0F0F0000; op_cnt=1.
- All four requesting continuously, with opa[i]=32'hFFFFFFFF and opb[i]=i → grants in order 0,1,2,3,0; resp_data = 0,1,2,3,0; a response every 2 cycles.
- Last pointer=1 with req=4'b1001 → grant to requester 3, then requester 0.
- Zero operands: opa=32'h0, opb=32'hFFFFFFFF → resp_data=32'h00000000. All-ones operands → resp_data=32'hFFFFFFFF.
- Reset asserted in EXEC → no resp_valid; gnt=0; op_cnt=0. Next request from requester 0 is granted first.
- CNTW=4 instance, 17 operations → op_cnt=1 after wrap.
